// File: rtl/game_flow_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_flow_pkg
//  Description : Shared definitions for the game-flow sequencer. It holds the
//                state codes and their width, and the constants used to split
//                an RGB word into its three colour channels.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_flow_pkg;

    // State register width and state codes
    localparam int         c_state_w     = 3;
    localparam logic [2:0] c_st_title    = 3'd0;
    localparam logic [2:0] c_st_fade_in  = 3'd1;
    localparam logic [2:0] c_st_playing  = 3'd2;
    localparam logic [2:0] c_st_fade_out = 3'd3;
    localparam logic [2:0] c_st_win      = 3'd4;
    localparam logic [2:0] c_st_over     = 3'd5;

    // An RGB word is R, G and B packed MSB first, all channels the same width
    localparam int         c_rgb_channels = 3;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser for a single asynchronous level.
//                The output clears on reset and then follows the input two
//                clocks late.
//  Ports       : clk  - destination clock
//                rst  - synchronous active-high reset
//                i_d  - asynchronous input level
//                o_q  - synchronised level
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/screen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : screen_sequencer
//  Description : Game-flow controller and screen compositor. It sequences
//                title -> fade-in -> playing -> fade-out -> win/over -> title.
//                It dims the playfield while paused and registers the
//                selected screen pixel on each pixel tick.
//  Ports       : clk_100MHz, reset          - clock, synchronous reset
//                p_tick, video_on, x, y     - VGA timing inputs
//                game_start, pause          - asynchronous level switches
//                win, game_over             - game core status
//                title/game/win/over_rgb    - screen sources
//                rgb                        - registered output pixel
//                state                      - current state code
//                game_rst                   - one-clock game core reset pulse
//                game_freeze                - freezes game motion
//                frame_cnt                  - free-running frame counter
//  Revision    : 1.0 - initial release
// ============================================================================
module screen_sequencer
    import game_flow_pkg::*;
#(
    parameter int RGB_W           = 12,
    parameter int FRAME_Y         = 481,
    parameter int FADE_FRAMES     = 16,
    parameter int MIN_HOLD_FRAMES = 60,
    parameter int FCNT_W          = 8
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              game_start,
    input  logic              pause,
    input  logic              win,
    input  logic              game_over,
    input  logic [RGB_W-1:0]  title_rgb,
    input  logic [RGB_W-1:0]  game_rgb,
    input  logic [RGB_W-1:0]  win_rgb,
    input  logic [RGB_W-1:0]  over_rgb,
    output logic [RGB_W-1:0]  rgb,
    output logic [2:0]        state,
    output logic              game_rst,
    output logic              game_freeze,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int c_chan_w = RGB_W / c_rgb_channels;
    localparam bit c_use_fade = (FADE_FRAMES > 0);

    // Fade counter only has to reach FADE_FRAMES-1: the last event transitions
    localparam int c_fade_w = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [c_fade_w-1:0] c_fade_last =
        c_fade_w'((FADE_FRAMES > 0) ? (FADE_FRAMES - 1) : 0);

    localparam int c_hold_w = (MIN_HOLD_FRAMES > 0) ? $clog2(MIN_HOLD_FRAMES + 1) : 1;
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MIN_HOLD_FRAMES);

    // ------------------------------------------------------------------
    // Switch synchronisers
    // ------------------------------------------------------------------
    logic w_gs;
    logic w_ps;

    sync_2ff u_sync_gs (
        .clk (clk_100MHz),
        .rst (reset),
        .i_d (game_start),
        .o_q (w_gs)
    );

    sync_2ff u_sync_ps (
        .clk (clk_100MHz),
        .rst (reset),
        .i_d (pause),
        .o_q (w_ps)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [2:0]          r_target;
    logic [c_fade_w-1:0] r_fade_cnt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_gs_prev;
    logic                r_armed;
    logic [1:0]          r_sync_warm;
    logic [RGB_W-1:0]    r_rgb;
    logic                r_game_rst;
    logic                r_game_freeze;
    logic [FCNT_W-1:0]   r_frame_cnt;

    // ------------------------------------------------------------------
    // Events
    // ------------------------------------------------------------------
    logic w_frame_end;
    logic w_gs_rise;
    logic w_hold_done;
    logic w_fade_done;

    assign w_frame_end = p_tick && (y == 10'(FRAME_Y)) && (x == 10'd0);
    // r_armed only sets once the synchroniser holds a real post-reset sample
    // showing the switch low, so a switch held high through reset cannot
    // start a game by itself.
    assign w_gs_rise   = w_gs && !r_gs_prev && r_armed;
    assign w_hold_done = (r_hold_cnt == c_hold_max);
    assign w_fade_done = w_frame_end && (r_fade_cnt == c_fade_last);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [2:0] w_state_next;
    logic [2:0] w_target_next;

    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        case (r_state)
            c_st_title: begin
                if (w_gs_rise)
                    w_state_next = c_use_fade ? c_st_fade_in : c_st_playing;
            end
            c_st_fade_in: begin
                if (!w_gs)
                    w_state_next = c_st_title;
                else if (w_fade_done)
                    w_state_next = c_st_playing;
            end
            c_st_playing: begin
                if (!w_gs) begin
                    w_state_next = c_st_title;
                end else if (win) begin
                    w_target_next = c_st_win;
                    w_state_next  = c_use_fade ? c_st_fade_out : c_st_win;
                end else if (game_over) begin
                    w_target_next = c_st_over;
                    w_state_next  = c_use_fade ? c_st_fade_out : c_st_over;
                end
            end
            c_st_fade_out: begin
                if (w_fade_done)
                    w_state_next = r_target;
            end
            c_st_win, c_st_over: begin
                if (w_hold_done && !w_gs)
                    w_state_next = c_st_title;
            end
            default: w_state_next = c_st_title;
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel selection
    // ------------------------------------------------------------------
    logic [RGB_W-1:0] w_game_dim;
    logic [RGB_W-1:0] w_rgb_next;

    for (genvar gi = 0; gi < c_rgb_channels; gi++) begin : g_dim
        assign w_game_dim[gi*c_chan_w +: c_chan_w] = game_rgb[gi*c_chan_w +: c_chan_w] >> 1;
    end

    always_comb begin
        w_rgb_next = '0;
        if (video_on) begin
            case (r_state)
                c_st_title:   w_rgb_next = title_rgb;
                c_st_playing: w_rgb_next = w_ps ? w_game_dim : game_rgb;
                c_st_win:     w_rgb_next = win_rgb;
                c_st_over:    w_rgb_next = over_rgb;
                default:      w_rgb_next = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state       <= c_st_title;
            r_target      <= c_st_win;
            r_fade_cnt    <= '0;
            r_hold_cnt    <= '0;
            r_gs_prev     <= 1'b0;
            r_armed       <= 1'b0;
            r_sync_warm   <= 2'd0;
            r_rgb         <= '0;
            r_game_rst    <= 1'b0;
            r_game_freeze <= 1'b1;
            r_frame_cnt   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_target      <= w_target_next;
            r_gs_prev     <= w_gs;
            r_game_rst    <= (r_state == c_st_title) && (w_state_next != c_st_title);
            r_game_freeze <= !((w_state_next == c_st_playing) && !w_ps);

            // Two clocks after reset both synchroniser stages hold real samples
            if (r_sync_warm != 2'd2)
                r_sync_warm <= r_sync_warm + 2'd1;
            if ((r_sync_warm == 2'd2) && !w_gs)
                r_armed <= 1'b1;

            if (w_frame_end)
                r_frame_cnt <= r_frame_cnt + 1'b1;

            // Counters restart on any state change; an event on that edge is dropped
            if (w_state_next != r_state) begin
                r_fade_cnt <= '0;
                r_hold_cnt <= '0;
            end else if (w_frame_end) begin
                if ((r_state == c_st_fade_in) || (r_state == c_st_fade_out))
                    r_fade_cnt <= r_fade_cnt + 1'b1;
                if (!w_hold_done)
                    r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            if (p_tick)
                r_rgb <= w_rgb_next;
        end
    end

    assign rgb         = r_rgb;
    assign state       = r_state;
    assign game_rst    = r_game_rst;
    assign game_freeze = r_game_freeze;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_screen_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_screen_sequencer
//  Description : Self-checking bench for screen_sequencer. One instance uses
//                the default fade/hold lengths, a second one has fades
//                disabled and a short hold. Expected values are queued as
//                stimulus is applied and compared when the outputs are due.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_sequencer;

    logic clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    logic        reset, p_tick, video_on;
    logic [9:0]  x, y;
    logic        game_start, pause, win, game_over;
    logic        game_start1, game_over1, win1;
    logic [11:0] title_rgb, game_rgb, win_rgb, over_rgb;

    logic [11:0] rgb, rgb1;
    logic [2:0]  state, state1;
    logic        game_rst, game_rst1, game_freeze, game_freeze1;
    logic [7:0]  frame_cnt, frame_cnt1;

    screen_sequencer #(
        .RGB_W(12), .FRAME_Y(481), .FADE_FRAMES(16), .MIN_HOLD_FRAMES(60), .FCNT_W(8)
    ) dut (
        .clk_100MHz (clk_100MHz), .reset (reset), .p_tick (p_tick), .video_on (video_on),
        .x (x), .y (y), .game_start (game_start), .pause (pause), .win (win),
        .game_over (game_over), .title_rgb (title_rgb), .game_rgb (game_rgb),
        .win_rgb (win_rgb), .over_rgb (over_rgb), .rgb (rgb), .state (state),
        .game_rst (game_rst), .game_freeze (game_freeze), .frame_cnt (frame_cnt)
    );

    screen_sequencer #(
        .RGB_W(12), .FRAME_Y(481), .FADE_FRAMES(0), .MIN_HOLD_FRAMES(4), .FCNT_W(8)
    ) dut_nofade (
        .clk_100MHz (clk_100MHz), .reset (reset), .p_tick (p_tick), .video_on (video_on),
        .x (x), .y (y), .game_start (game_start1), .pause (pause), .win (win1),
        .game_over (game_over1), .title_rgb (title_rgb), .game_rgb (game_rgb),
        .win_rgb (win_rgb), .over_rgb (over_rgb), .rgb (rgb1), .state (state1),
        .game_rst (game_rst1), .game_freeze (game_freeze1), .frame_cnt (frame_cnt1)
    );

    // Scoreboard
    string       q_tag[$];
    logic [31:0] q_exp[$];
    int          n_checks   = 0;
    int          n_err      = 0;
    int          rst_pulses = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_exp.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_checks++;
        if (q_exp.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: observed=%0h expected=<none>", obs);
        end else begin
            t = q_tag.pop_front();
            e = q_exp.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
        if (game_rst) rst_pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One clock with the end-of-frame coordinate presented
    task automatic frame();
        x = 10'd0;
        y = 10'd481;
        tick();
        x = 10'd1;
        y = 10'd0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; p_tick = 1'b1; video_on = 1'b1; x = 10'd1; y = 10'd0;
        game_start = 1'b1; pause = 1'b0; win = 1'b0; game_over = 1'b0;
        game_start1 = 1'b0; game_over1 = 1'b0; win1 = 1'b0;
        title_rgb = 12'h123; game_rgb = 12'hFFF; win_rgb = 12'h0F0; over_rgb = 12'hF00;

        // Reset values
        expect_val("reset_state", 0); expect_val("reset_rgb", 0);
        expect_val("reset_game_rst", 0); expect_val("reset_freeze", 1);
        expect_val("reset_frame_cnt", 0);
        ticks(3);
        check(32'(state)); check(32'(rgb)); check(32'(game_rst));
        check(32'(game_freeze)); check(32'(frame_cnt));

        // Switch held high through reset does not start a game
        reset = 1'b0;
        expect_val("held_gs_state", 0); expect_val("held_gs_no_rst", 0);
        expect_val("held_gs_frame_cnt", 10); expect_val("title_rgb", 12'h123);
        frames(10);
        check(32'(state)); check(32'(rst_pulses)); check(32'(frame_cnt)); check(32'(rgb));

        // Low then high: start after 3 clocks with a one-clock game_rst
        game_start = 1'b0;
        ticks(3);
        game_start = 1'b1;
        rst_pulses = 0;
        expect_val("start_clk2_state", 0);
        ticks(2); check(32'(state));
        expect_val("start_clk3_state", 1); expect_val("start_game_rst", 1);
        tick(); check(32'(state)); check(32'(game_rst));
        expect_val("start_game_rst_end", 0); expect_val("fade_in_rgb", 0);
        expect_val("start_rst_count", 1);
        tick(); check(32'(game_rst)); check(32'(rgb)); check(32'(rst_pulses));

        // Fade-in lasts 16 frame events
        expect_val("fade_in_15_state", 1); expect_val("fade_in_15_rgb", 0);
        frames(15); check(32'(state)); check(32'(rgb));
        expect_val("playing_state", 2); expect_val("playing_freeze", 0);
        frame(); check(32'(state)); check(32'(game_freeze));
        expect_val("playing_rgb", 12'hFFF);
        tick(); check(32'(rgb));

        // Pause dims and freezes from clock 3
        pause = 1'b1;
        expect_val("pause_clk2_freeze", 0);
        ticks(2); check(32'(game_freeze));
        expect_val("pause_clk3_freeze", 1); expect_val("pause_rgb", 12'h777);
        expect_val("pause_state", 2);
        tick(); check(32'(game_freeze)); check(32'(rgb)); check(32'(state));
        pause = 1'b0;
        expect_val("unpause_freeze", 0); expect_val("unpause_rgb", 12'hFFF);
        ticks(3); check(32'(game_freeze)); check(32'(rgb));

        // Win and game_over together: win has priority
        win = 1'b1; game_over = 1'b1;
        expect_val("fade_out_state", 3); expect_val("fade_out_freeze", 1);
        tick(); check(32'(state)); check(32'(game_freeze));
        win = 1'b0; game_over = 1'b0;
        expect_val("fade_out_15_state", 3); expect_val("fade_out_rgb", 0);
        frames(15); check(32'(state)); check(32'(rgb));
        expect_val("win_state", 4);
        frame(); check(32'(state));
        expect_val("win_rgb", 12'h0F0);
        tick(); check(32'(rgb));
        expect_val("win_gs_high_state", 4);
        frames(60); check(32'(state));
        game_start = 1'b0;
        expect_val("win_exit_clk2", 4);
        ticks(2); check(32'(state));
        expect_val("win_exit_clk3", 0);
        tick(); check(32'(state));

        // Game over path with minimum hold
        game_start = 1'b1;
        expect_val("over_fade_in", 1);
        ticks(3); check(32'(state));
        expect_val("over_playing", 2);
        frames(16); check(32'(state));
        game_over = 1'b1;
        expect_val("over_fade_out", 3);
        tick(); check(32'(state));
        game_over = 1'b0;
        expect_val("over_state", 5);
        frames(16); check(32'(state));
        expect_val("over_rgb", 12'hF00);
        tick(); check(32'(rgb));
        frames(10);
        game_start = 1'b0;
        expect_val("over_hold_10", 5);
        ticks(3); check(32'(state));
        expect_val("over_hold_59", 5);
        frames(49); check(32'(state));
        expect_val("over_hold_60", 5);
        frame(); check(32'(state));
        expect_val("over_to_title", 0);
        tick(); check(32'(state));

        // Abort from PLAYING
        game_start = 1'b1;
        ticks(3); frames(16);
        expect_val("abort_playing", 2); check(32'(state));
        game_start = 1'b0;
        expect_val("abort_clk2", 2);
        ticks(2); check(32'(state));
        expect_val("abort_clk3", 0);
        tick(); check(32'(state));

        // Reset in the middle of FADE_OUT
        game_start = 1'b1;
        ticks(3); frames(16);
        win = 1'b1; tick(); win = 1'b0;
        expect_val("pre_reset_fade_out", 3); check(32'(state));
        frames(5);
        reset = 1'b1;
        expect_val("midfade_reset_state", 0); expect_val("midfade_reset_rgb", 0);
        expect_val("midfade_reset_frame_cnt", 0); expect_val("midfade_reset_game_rst", 0);
        tick(); check(32'(state)); check(32'(rgb)); check(32'(frame_cnt)); check(32'(game_rst));
        reset = 1'b0;
        rst_pulses = 0;
        expect_val("post_reset_state", 0); expect_val("post_reset_no_rst", 0);
        frames(5); check(32'(state)); check(32'(rst_pulses));

        // Frame counter wrap
        expect_val("frame_cnt_255", 255);
        frames(250); check(32'(frame_cnt));
        expect_val("frame_cnt_wrap", 0);
        frame(); check(32'(frame_cnt));

        // Fade-less build: straight to PLAYING and OVER
        game_start1 = 1'b1;
        expect_val("nofade_clk2_state", 0);
        ticks(2); check(32'(state1));
        expect_val("nofade_playing", 2); expect_val("nofade_game_rst", 1);
        expect_val("nofade_freeze", 0);
        tick(); check(32'(state1)); check(32'(game_rst1)); check(32'(game_freeze1));
        game_over1 = 1'b1;
        expect_val("nofade_over", 5);
        tick(); check(32'(state1));
        game_over1 = 1'b0;
        expect_val("nofade_over_rgb", 12'hF00);
        tick(); check(32'(rgb1));
        game_start1 = 1'b0;
        ticks(3);
        expect_val("nofade_hold_3", 5);
        frames(3); check(32'(state1));
        expect_val("nofade_hold_4", 5);
        frame(); check(32'(state1));
        expect_val("nofade_to_title", 0);
        tick(); check(32'(state1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/screen_sequencer.md
# screen_sequencer

Parametrised game-flow controller and screen compositor for the VGA game top level. It runs the title / playing / win / game-over flow, adds timed black-out transitions and a minimum end-screen hold, and dims the playfield while paused. It picks one of four screen RGB sources and registers the result on the pixel tick. It sits between the VGA controller, the screen generators and the game core, and drives the core's freeze and reset inputs.

## Interface
Parameters:
- RGB_W, 12: pixel width; must be a multiple of 3 (R, G, B each RGB_W/3 bits).
- FRAME_Y, 481: y line on which the end-of-frame event fires.
- FADE_FRAMES, 16: length of each black-out transition in frames; 0 disables the fade states.
- MIN_HOLD_FRAMES, 60: minimum frames the win or game-over screen is shown.
- FCNT_W, 8: width of the exported frame counter.

Ports (one clock; reset is synchronous and active-high):
- clk_100MHz  in  1  system clock.
- reset  in  1  synchronous, active-high.
- p_tick  in  1  pixel enable from the VGA controller.
- video_on  in  1  active display area.
- x, y  in  10 each  current pixel coordinate.
- game_start  in  1  level switch, asynchronous.
- pause  in  1  level switch, asynchronous.
- win, game_over  in  1 each  status from the game core, synchronous.
- title_rgb, game_rgb, win_rgb, over_rgb  in  RGB_W each  screen sources.
- rgb  out  RGB_W  registered pixel.
- state  out  3  current state code.
- game_rst  out  1  one-cycle pulse that resets the game core.
- game_freeze  out  1  freezes game motion.
- frame_cnt  out  FCNT_W  free-running frame count.

## Operation
- game_start and pause each pass through a 2-FF synchronizer. Below, gs and ps are the synchronized values.
- gs_rise is gs high with the previous gs low.
- frame_end = p_tick & (y == FRAME_Y) & (x == 0). frame_cnt increments on every frame_end and wraps modulo 2^FCNT_W.
- State transitions:
  - TITLE: on gs_rise, go to FADE_IN and pulse game_rst. A level-high gs on entry to TITLE does not start a game.
  - FADE_IN: if !gs, go to TITLE. Otherwise, after FADE_FRAMES frame_end events, go to PLAYING.
  - PLAYING: if !gs, go to TITLE (abort). Else if win, go to FADE_OUT with target WIN. Else if game_over, go to FADE_OUT with target OVER. win takes priority when win and game_over are high together.
  - FADE_OUT: after FADE_FRAMES frame_end events, go to the latched target. gs is ignored here.
  - WIN / OVER: a hold counter counts frame_end events and saturates at MIN_HOLD_FRAMES. When hold is satisfied and !gs, go to TITLE.
- With FADE_FRAMES = 0, FADE_IN and FADE_OUT are never entered. Transitions go straight to PLAYING or to the target.
- The fade counter and hold counter clear on every state entry. A frame_end in the cycle of entry is not counted.
- Pixel selection (rgb_next):
  - video_on low: 0.
  - TITLE: title_rgb.
  - FADE_IN, FADE_OUT: 0.
  - PLAYING with ps: each channel of game_rgb shifted right by 1 (half brightness).
  - PLAYING without ps: game_rgb.
  - WIN: win_rgb.
  - OVER: over_rgb.
- game_freeze = !(state == PLAYING && !ps).
- State codes: TITLE=0, FADE_IN=1, PLAYING=2, FADE_OUT=3, WIN=4, OVER=5. Codes 6 and 7 are illegal and go to TITLE on the next clock.

## Timing
- rgb updates only on the p_tick cycle, one p_tick after the inputs are sampled. No other pipeline stage.
- The state register updates every clock. Switch-to-state latency is 3 clocks: 2 synchronizer stages plus the state flop.
- game_rst is high for exactly the clock on which the state leaves TITLE. It is registered.
- game_freeze and state are registered, aligned with the state flop.
- Reset values: state TITLE, rgb 0, game_rst 0, game_freeze 1, frame_cnt 0, synchronizers 0, counters 0.
- Reset mid-fade or mid-hold returns to TITLE with no game_rst pulse. A switch left high through reset needs a low-to-high cycle before a game starts.

## Structure
- Package game_flow_pkg holds the state codes, the state width (3) and the RGB channel split helper constants.
- Sub-module sync_2ff (1-bit, with reset), instantiated twice.
- The screen generators stay outside this block.

## Test plan
- Reset with gs high, hold 10 frames -> stays TITLE, game_rst never asserted. Toggle low then high -> game_rst pulse, FADE_IN, rgb 0 for 16 frames, then PLAYING.
- PLAYING, game_rgb=12'hFFF, pause high -> rgb=12'h777 and game_freeze=1 from clock 3. Pause low -> rgb=12'hFFF.
- PLAYING, win and game_over both pulsed in the same cycle -> FADE_OUT, then WIN after 16 frame_end events.
- OVER, drop gs at frame 10 -> stays OVER until hold reaches 60, TITLE on the next clock.
- FADE_FRAMES=0 build: gs_rise -> PLAYING directly. game_over -> OVER directly.
- PLAYING, drop gs -> TITLE in 3 clocks. Assert reset in the middle of FADE_OUT -> TITLE, rgb 0, frame_cnt 0. Run 256 frames -> frame_cnt wraps to 0.
